// File: rtl/pcs_pkg.sv
// Shared PCS constants and types: sync-header encodings, lock-FSM states and
// default window/threshold values (also intended for a later BER monitor).
package pcs_pkg;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   localparam int DEF_DATA_WIDTH     = 64;
   localparam int DEF_SH_WINDOW      = 64;
   localparam int DEF_INVLD_MAX      = 16;
   localparam int DEF_SLIP_WAIT_BLKS = 4;

   typedef enum logic {
      TEST      = 1'b0,
      SLIP_WAIT = 1'b1
   } sync_state_t;

   function automatic logic sh_is_ok(input logic [1:0] hdr);
      return (hdr == SH_DATA) || (hdr == SH_CTRL);
   endfunction

endpackage

// File: rtl/pcs_block_lock_fsm.sv
// Block-lock hunt/hold FSM with window, invalid-header and slip-settle counters.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   TEST      | checking headers; counting window blocks and invalid headers
//   SLIP_WAIT | gearbox settling after a slip; headers ignored
module pcs_block_lock_fsm
   import pcs_pkg::*;
#(
   parameter int SH_WINDOW      = DEF_SH_WINDOW,
   parameter int INVLD_MAX      = DEF_INVLD_MAX,
   parameter int SLIP_WAIT_BLKS = DEF_SLIP_WAIT_BLKS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       blk_valid_i,
   input  logic [1:0] header_i,
   output logic       block_lock_o,
   output logic       slip_o
);

   localparam int SH_CW = $clog2(SH_WINDOW + 1);
   localparam int IV_CW = $clog2(INVLD_MAX + 1);
   localparam int WT_CW = $clog2(SLIP_WAIT_BLKS + 1);

   sync_state_t        state_q, state_d;
   logic [SH_CW-1:0]   sh_cnt_q, sh_cnt_d, cnt_n;
   logic [IV_CW-1:0]   invld_cnt_q, invld_cnt_d, inv_n;
   logic [WT_CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic               lock_q, lock_d;
   logic               slip_q, slip_d;
   logic               sh_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= TEST;
         sh_cnt_q    <= '0;
         invld_cnt_q <= '0;
         wait_cnt_q  <= '0;
         lock_q      <= 1'b0;
         slip_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_cnt_q    <= sh_cnt_d;
         invld_cnt_q <= invld_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         lock_q      <= lock_d;
         slip_q      <= slip_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sh_cnt_d    = sh_cnt_q;
      invld_cnt_d = invld_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      lock_d      = lock_q;
      slip_d      = 1'b0;
      sh_ok       = sh_is_ok(header_i);
      cnt_n       = sh_cnt_q + SH_CW'(1);
      inv_n       = invld_cnt_q + IV_CW'(!sh_ok);

      if (blk_valid_i) begin
         unique case (state_q)
            TEST: begin
               // A bad header while hunting slips at once; while locked only the
               // INVLD_MAX-th bad header in a window drops lock.
               if (!sh_ok && (!lock_q || inv_n == IV_CW'(INVLD_MAX))) begin
                  lock_d      = 1'b0;
                  slip_d      = 1'b1;
                  sh_cnt_d    = '0;
                  invld_cnt_d = '0;
                  wait_cnt_d  = '0;
                  state_d     = SLIP_WAIT;
               end else if (cnt_n == SH_CW'(SH_WINDOW)) begin
                  if (inv_n == '0) lock_d = 1'b1;
                  sh_cnt_d    = '0;
                  invld_cnt_d = '0;
               end else begin
                  sh_cnt_d    = cnt_n;
                  invld_cnt_d = inv_n;
               end
            end
            SLIP_WAIT: begin
               if (wait_cnt_q == WT_CW'(SLIP_WAIT_BLKS - 1)) begin
                  wait_cnt_d = '0;
                  state_d    = TEST;
               end else begin
                  wait_cnt_d = wait_cnt_q + WT_CW'(1);
               end
            end
            default: state_d = TEST;
         endcase
      end
   end

   assign block_lock_o = lock_q;
   assign slip_o       = slip_q;

endmodule

// File: rtl/pcs_rx_block_sync.sv
// Rx PCS block-sync top: lock FSM plus a one-stage payload register that only
// presents valid data to the descrambler while block lock is held.
module pcs_rx_block_sync
   import pcs_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int SH_WINDOW      = DEF_SH_WINDOW,
   parameter int INVLD_MAX      = DEF_INVLD_MAX,
   parameter int SLIP_WAIT_BLKS = DEF_SLIP_WAIT_BLKS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            header_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   output logic                  slip,
   output logic                  block_lock,
   output logic [DATA_WIDTH-1:0] desc_data,
   output logic [1:0]            desc_header,
   output logic                  desc_valid
);

   logic [DATA_WIDTH-1:0] desc_data_q;
   logic [1:0]            desc_header_q;
   logic                  desc_valid_q;
   logic                  lock_w;

   pcs_block_lock_fsm #(
      .SH_WINDOW      (SH_WINDOW),
      .INVLD_MAX      (INVLD_MAX),
      .SLIP_WAIT_BLKS (SLIP_WAIT_BLKS)
   ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .blk_valid_i  (data_in_valid),
      .header_i     (header_in),
      .block_lock_o (lock_w),
      .slip_o       (slip)
   );

   // Valid gating uses the lock value before this block's update, so the block
   // that completes the lock window is not itself forwarded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         desc_data_q   <= '0;
         desc_header_q <= '0;
         desc_valid_q  <= 1'b0;
      end else begin
         desc_valid_q <= data_in_valid & lock_w;
         if (data_in_valid) begin
            desc_data_q   <= data_in;
            desc_header_q <= header_in;
         end
      end
   end

   assign block_lock  = lock_w;
   assign desc_data   = desc_data_q;
   assign desc_header = desc_header_q;
   assign desc_valid  = desc_valid_q;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Directed + randomized bench for pcs_rx_block_sync against a block-level reference model.
module tb_pcs_rx_block_sync;

   logic        clk;
   logic        rst;
   logic [1:0]  header_in;
   logic [63:0] data_in;
   logic        data_in_valid;
   logic        slip;
   logic        block_lock;
   logic [63:0] desc_data;
   logic [1:0]  desc_header;
   logic        desc_valid;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_lock, m_win, m_bad, m_settle;
   logic        e_slip, e_dvalid;
   logic [63:0] e_data;
   logic [1:0]  e_hdr;

   pcs_rx_block_sync dut (
      .clk           (clk),
      .rst           (rst),
      .header_in     (header_in),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .slip          (slip),
      .block_lock    (block_lock),
      .desc_data     (desc_data),
      .desc_header   (desc_header),
      .desc_valid    (desc_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_lock = 0; m_win = 0; m_bad = 0; m_settle = 0;
      e_slip = 1'b0; e_dvalid = 1'b0; e_data = '0; e_hdr = '0;
   endtask

   task automatic model_block(input logic v, input logic [1:0] h, input logic [63:0] d);
      bit good;
      e_slip   = 1'b0;
      e_dvalid = v && (m_lock != 0);
      if (v) begin
         e_data = d;
         e_hdr  = h;
         good   = (h == 2'b01) || (h == 2'b10);
         if (m_settle > 0) begin
            m_settle--;
         end else if (!good && (m_lock == 0 || m_bad + 1 == 16)) begin
            m_lock = 0; m_win = 0; m_bad = 0; m_settle = 4;
            e_slip = 1'b1;
         end else begin
            m_win++;
            if (!good) m_bad++;
            if (m_win == 64) begin
               if (m_bad == 0) m_lock = 1;
               m_win = 0; m_bad = 0;
            end
         end
      end
   endtask

   task automatic step(input logic v, input logic [1:0] h);
      logic [63:0] d;
      d = {$urandom, $urandom};
      @(negedge clk);
      data_in_valid = v; header_in = h; data_in = d;
      model_block(v, h, d);
      @(posedge clk);
      #1;
      chk("slip", 64'(slip), 64'(e_slip));
      chk("block_lock", 64'(block_lock), 64'(m_lock != 0));
      chk("desc_valid", 64'(desc_valid), 64'(e_dvalid));
      chk("desc_data", desc_data, e_data);
      chk("desc_header", 64'(desc_header), 64'(e_hdr));
   endtask

   function automatic logic [1:0] rnd_hdr(input int bad_pct);
      logic [1:0] h;
      if (int'($urandom_range(99)) < bad_pct) h = $urandom_range(1) ? 2'b11 : 2'b00;
      else                                    h = $urandom_range(1) ? 2'b10 : 2'b01;
      return h;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_slip", 64'(slip), 64'd0);
      chk("rst_lock", 64'(block_lock), 64'd0);
      chk("rst_desc_valid", 64'(desc_valid), 64'd0);
      chk("rst_desc_data", desc_data, 64'd0);
      chk("rst_desc_header", 64'(desc_header), 64'd0);
      model_clear();
      data_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_slip", 64'(slip), 64'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; header_in = 2'b00; data_in = '0; data_in_valid = 1'b0;
      model_clear();

      // 1: clean acquisition
      apply_reset();
      repeat (63) step(1'b1, rnd_hdr(0));
      chk("t1_lock_after_63", 64'(block_lock), 64'd0);
      step(1'b1, rnd_hdr(0));
      chk("t1_lock_after_64", 64'(block_lock), 64'd1);
      repeat (64) step(1'b1, rnd_hdr(0));

      // 3: 15 invalid in one window keeps lock
      repeat (15) step(1'b1, 2'b11);
      repeat (49) step(1'b1, rnd_hdr(0));
      chk("t3_lock_held", 64'(block_lock), 64'd1);
      repeat (64) step(1'b1, rnd_hdr(0));
      chk("t3_still_locked", 64'(block_lock), 64'd1);

      // 4: 16th invalid in a window drops lock and slips
      repeat (15) step(1'b1, 2'b00);
      step(1'b1, 2'b11);
      chk("t4_unlock", 64'(block_lock), 64'd0);
      chk("t4_slip", 64'(slip), 64'd1);
      step(1'b1, rnd_hdr(0));
      chk("t4_desc_valid_off", 64'(desc_valid), 64'd0);

      // 2: slip during hunt, settle blocks ignored, then reacquire
      apply_reset();
      repeat (9) step(1'b1, rnd_hdr(0));
      step(1'b1, 2'b00);
      chk("t2_slip", 64'(slip), 64'd1);
      step(1'b1, 2'b11);
      chk("t2_slip_one_cycle", 64'(slip), 64'd0);
      repeat (3) step(1'b1, 2'b00);
      repeat (64) step(1'b1, rnd_hdr(0));
      chk("t2_relock", 64'(block_lock), 64'd1);

      // 5: valid toggling during hunt
      apply_reset();
      for (int i = 0; i < 64; i++) begin
         step(1'b1, rnd_hdr(0));
         step(1'b0, rnd_hdr(50));
      end
      chk("t5_lock_gapped", 64'(block_lock), 64'd1);

      // 6: reset mid-settle and while locked
      apply_reset();
      step(1'b1, 2'b00);
      repeat (2) step(1'b1, rnd_hdr(0));
      apply_reset();
      repeat (64) step(1'b1, rnd_hdr(0));
      chk("t6_lock_after_rst", 64'(block_lock), 64'd1);
      step(1'b1, rnd_hdr(0));
      apply_reset();
      repeat (64) step(1'b1, rnd_hdr(0));
      chk("t6_lock_recover", 64'(block_lock), 64'd1);

      // random: gappy traffic, light then heavy header corruption
      for (int i = 0; i < 600; i++) step($urandom_range(3) != 0, rnd_hdr(2));
      for (int i = 0; i < 600; i++) step($urandom_range(3) != 0, rnd_hdr(25));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
